// File: rtl/niosinst_debug_scan_pkg.sv
// Shared state encoding and default widths for the virtual-JTAG debug scan master.
package niosinst_debug_scan_pkg;

   localparam int DR_WIDTH_DEF = 38;
   localparam int IR_WIDTH_DEF = 2;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_UIR  = 3'd1,
      ST_CDR  = 3'd2,
      ST_SDR  = 3'd3,
      ST_E1DR = 3'd4,
      ST_RSP  = 3'd5
   } scan_state_e;

   // TCK only runs while a scan is actually walking the virtual TAP.
   function automatic logic tck_active(input scan_state_e st);
      return (st != ST_IDLE) && (st != ST_RSP);
   endfunction

endpackage

// File: rtl/niosinst_debug_scan_tckgen.sv
// TCK divider: low half first, TCK_DIV clk cycles per half, with one-clk rise/fall event pulses.
module niosinst_debug_scan_tckgen #(
   parameter int TCK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   output logic o_tck,
   output logic o_rise_en,
   output logic o_fall_en
);

   localparam int            CW      = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
   localparam logic [CW-1:0] LP_TERM = CW'(TCK_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          r_tck;
   logic          w_term;

   assign w_term    = (r_cnt == LP_TERM);
   assign o_rise_en = i_en && w_term && !r_tck;
   assign o_fall_en = i_en && w_term && r_tck;
   assign o_tck     = r_tck;

   // Half-period counter; parked low with a cleared count whenever disabled.
   always_ff @(posedge clk) begin
      if (reset || !i_en) begin
         r_cnt <= {CW{1'b0}};
         r_tck <= 1'b0;
      end else if (w_term) begin
         r_cnt <= {CW{1'b0}};
         r_tck <= ~r_tck;
      end else begin
         r_cnt <= r_cnt + CW'(1'b1);
      end
   end

endmodule

// File: rtl/niosinst_debug_scan_master.sv
// Virtual-JTAG scan initiator: loads IR, captures and shifts one DR word over a divided TCK.
// Optional IR readback is enabled by defining NIOSINST_DEBUG_SCAN_IR_CAPTURE_EN.
module niosinst_debug_scan_master
   import niosinst_debug_scan_pkg::*;
#(
   parameter int DR_WIDTH = DR_WIDTH_DEF,
   parameter int IR_WIDTH = IR_WIDTH_DEF,
   parameter int TCK_DIV  = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_dr,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DR_WIDTH-1:0] rsp_dr,
   output logic [IR_WIDTH-1:0] rsp_ir,
   output logic                vs_tck,
   output logic                vs_tdi,
   input  logic                vs_tdo,
   output logic [IR_WIDTH-1:0] vs_ir_in,
   input  logic [IR_WIDTH-1:0] vs_ir_out,
   output logic                vs_uir,
   output logic                vs_cdr,
   output logic                vs_sdr,
   output logic                vs_e1dr,
   output logic                vs_rti
);

   localparam int            BW      = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
   localparam logic [BW-1:0] LP_LAST = BW'(DR_WIDTH - 1);

   scan_state_e         r_state;
   logic [BW-1:0]       r_bit_cnt;
   logic [DR_WIDTH-1:0] r_tx;
   logic [DR_WIDTH-1:0] r_cap;
   logic [DR_WIDTH-1:0] r_rsp_dr;
   logic [IR_WIDTH-1:0] r_ir_in;
   logic                r_tdi, r_uir, r_cdr, r_sdr, r_e1dr, r_rti, r_rsp_valid;
   logic                w_tck, w_rise_en, w_fall_en;
   logic [DR_WIDTH-1:0] w_tx_shift;

   assign w_tx_shift = r_tx >> 1;

   niosinst_debug_scan_tckgen #(.TCK_DIV(TCK_DIV)) u_tckgen (
      .clk       (clk),
      .reset     (reset),
      .i_en      (tck_active(r_state)),
      .o_tck     (w_tck),
      .o_rise_en (w_rise_en),
      .o_fall_en (w_fall_en)
   );

   // Scan sequencer: every state/strobe/tdi change lands on a TCK falling event, TDO on rising.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_bit_cnt   <= {BW{1'b0}};
         r_tx        <= {DR_WIDTH{1'b0}};
         r_cap       <= {DR_WIDTH{1'b0}};
         r_rsp_dr    <= {DR_WIDTH{1'b0}};
         r_ir_in     <= {IR_WIDTH{1'b0}};
         r_tdi       <= 1'b0;
         r_uir       <= 1'b0;
         r_cdr       <= 1'b0;
         r_sdr       <= 1'b0;
         r_e1dr      <= 1'b0;
         r_rti       <= 1'b1;
         r_rsp_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_state <= ST_UIR;
                  r_tx    <= cmd_dr;
                  r_ir_in <= cmd_ir;
                  r_cap   <= {DR_WIDTH{1'b0}};
                  r_rti   <= 1'b0;
                  r_uir   <= 1'b1;
               end
            end
            ST_UIR: begin
               if (w_fall_en) begin
                  r_state <= ST_CDR;
                  r_uir   <= 1'b0;
                  r_cdr   <= 1'b1;
               end
            end
            ST_CDR: begin
               if (w_fall_en) begin
                  r_state   <= ST_SDR;
                  r_cdr     <= 1'b0;
                  r_sdr     <= 1'b1;
                  r_tdi     <= r_tx[0];
                  r_bit_cnt <= {BW{1'b0}};
               end
            end
            ST_SDR: begin
               if (w_rise_en) begin
                  r_cap <= {vs_tdo, r_cap[DR_WIDTH-1:1]};
               end
               if (w_fall_en) begin
                  r_tx <= w_tx_shift;
                  if (r_bit_cnt == LP_LAST) begin
                     r_state <= ST_E1DR;
                     r_sdr   <= 1'b0;
                     r_e1dr  <= 1'b1;
                     r_tdi   <= 1'b0;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + BW'(1'b1);
                     r_tdi     <= w_tx_shift[0];
                  end
               end
            end
            ST_E1DR: begin
               if (w_fall_en) begin
                  r_state     <= ST_RSP;
                  r_e1dr      <= 1'b0;
                  r_rti       <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_rsp_dr    <= r_cap;
               end
            end
            ST_RSP: begin
               if (rsp_ready) begin
                  r_state     <= ST_IDLE;
                  r_rsp_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_tdi       <= 1'b0;
               r_uir       <= 1'b0;
               r_cdr       <= 1'b0;
               r_sdr       <= 1'b0;
               r_e1dr      <= 1'b0;
               r_rti       <= 1'b1;
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef NIOSINST_DEBUG_SCAN_IR_CAPTURE_EN
   logic [IR_WIDTH-1:0] r_ir_cap;
   logic [IR_WIDTH-1:0] r_rsp_ir;

   // Slave IR readback taken mid-UIR, published together with the DR response.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ir_cap <= {IR_WIDTH{1'b0}};
         r_rsp_ir <= {IR_WIDTH{1'b0}};
      end else begin
         if ((r_state == ST_UIR) && w_rise_en) begin
            r_ir_cap <= vs_ir_out;
         end
         if ((r_state == ST_E1DR) && w_fall_en) begin
            r_rsp_ir <= r_ir_cap;
         end
      end
   end

   assign rsp_ir = r_rsp_ir;
`else
   logic w_unused_ir;
   assign w_unused_ir = ^vs_ir_out;
   assign rsp_ir      = {IR_WIDTH{1'b0}};
`endif

   assign cmd_ready = (r_state == ST_IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_dr    = r_rsp_dr;
   assign vs_tck    = w_tck;
   assign vs_tdi    = r_tdi;
   assign vs_ir_in  = r_ir_in;
   assign vs_uir    = r_uir;
   assign vs_cdr    = r_cdr;
   assign vs_sdr    = r_sdr;
   assign vs_e1dr   = r_e1dr;
   assign vs_rti    = r_rti;

endmodule

// File: tb/tb_niosinst_debug_scan_master.sv
// Directed bench for niosinst_debug_scan_master with an echo/tied-high slave model.
module tb_niosinst_debug_scan_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_ir;
   logic [37:0] cmd_dr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [37:0] rsp_dr;
   logic [1:0]  rsp_ir;
   logic        vs_tck, vs_tdi, vs_tdo;
   logic [1:0]  vs_ir_in;
   logic [1:0]  vs_ir_out;
   logic        vs_uir, vs_cdr, vs_sdr, vs_e1dr, vs_rti;

   logic        tdo_tied;
   logic        echo_tdo;
   logic        last_tdi;
   logic        prev_tck;
   int          n_uir, n_cdr, n_sdr, n_e1dr;
   logic [37:0] tdi_seq;
   int          checks = 0;
   int          errors = 0;
   int          lat;
   logic [37:0] hold_dr;
   logic        flag_ok;

`ifdef NIOSINST_DEBUG_SCAN_IR_CAPTURE_EN
   localparam logic [1:0] EXP_IR = 2'b10;
`else
   localparam logic [1:0] EXP_IR = 2'b00;
`endif

   assign vs_tdo = tdo_tied ? 1'b1 : echo_tdo;

   always #5 clk = ~clk;

   niosinst_debug_scan_master dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_ir    (cmd_ir),
      .cmd_dr    (cmd_dr),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_dr    (rsp_dr),
      .rsp_ir    (rsp_ir),
      .vs_tck    (vs_tck),
      .vs_tdi    (vs_tdi),
      .vs_tdo    (vs_tdo),
      .vs_ir_in  (vs_ir_in),
      .vs_ir_out (vs_ir_out),
      .vs_uir    (vs_uir),
      .vs_cdr    (vs_cdr),
      .vs_sdr    (vs_sdr),
      .vs_e1dr   (vs_e1dr),
      .vs_rti    (vs_rti)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clk step; the slave watches TCK edges: echo returns the tdi seen at the previous rise.
   task automatic tick();
      @(posedge clk);
      #1;
      if (vs_tck && !prev_tck) begin
         last_tdi = vs_tdi;
         if (vs_uir)  n_uir++;
         if (vs_cdr)  n_cdr++;
         if (vs_e1dr) n_e1dr++;
         if (vs_sdr) begin
            if (n_sdr < 38) tdi_seq[n_sdr] = vs_tdi;
            n_sdr++;
         end
      end else if (!vs_tck && prev_tck) begin
         echo_tdo = last_tdi;
      end
      prev_tck = vs_tck;
   endtask

   task automatic clear_mon();
      n_uir = 0; n_cdr = 0; n_sdr = 0; n_e1dr = 0;
      tdi_seq = 38'h0;
   endtask

   task automatic wait_rsp(output int l);
      l = -1;
      for (int k = 1; k <= 400; k++) begin
         tick();
         if (rsp_valid === 1'b1) begin
            l = k;
            break;
         end
      end
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_ir = 2'b00; cmd_dr = 38'h0;
      rsp_ready = 1'b0; tdo_tied = 1'b0; echo_tdo = 1'b0; last_tdi = 1'b0;
      prev_tck = 1'b0; vs_ir_out = 2'b10;
      clear_mon();

      // Reset and idle
      repeat (3) tick();
      reset = 1'b0;
      repeat (10) tick();
      chk("idle_strobes", {vs_uir, vs_cdr, vs_sdr, vs_e1dr, vs_rti}, 5'b00001);
      chk("idle_tck", vs_tck, 1'b0);
      chk("idle_cmd_ready", cmd_ready, 1'b1);
      chk("idle_tdi", vs_tdi, 1'b0);
      chk("idle_ir_in", vs_ir_in, 2'b00);
      chk("idle_rsp", {rsp_valid, rsp_dr, rsp_ir}, 41'h0);

      // Scan 1: echo slave, response held back
      cmd_ir = 2'b01; cmd_dr = 38'h2A_5A5A_5A5A; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0; cmd_ir = 2'b11; cmd_dr = 38'h3F_FFFF_FFFF;
      chk("s1_ir_in", vs_ir_in, 2'b01);
      chk("s1_busy", cmd_ready, 1'b0);
      chk("s1_uir", {vs_uir, vs_rti}, 2'b10);
      wait_rsp(lat);
      chk("s1_latency", lat, 164);
      chk("s1_rsp_dr", rsp_dr, 38'h14_B4B4_B4B4);
      chk("s1_tdi_seq", tdi_seq, 38'h2A_5A5A_5A5A);
      chk("s1_rsp_ir", rsp_ir, EXP_IR);
      chk("s1_rsp_tck_rti", {vs_tck, vs_rti}, 2'b01);

      // Hold response 20 cycles while a new command is offered
      hold_dr = rsp_dr; flag_ok = 1'b1;
      cmd_valid = 1'b1; cmd_ir = 2'b11; cmd_dr = 38'h15_5555_5555;
      repeat (20) begin
         tick();
         if (rsp_valid !== 1'b1 || rsp_dr !== hold_dr || cmd_ready !== 1'b0 || vs_uir !== 1'b0)
            flag_ok = 1'b0;
      end
      chk("hold_stable", flag_ok, 1'b1);
      tdo_tied = 1'b1; rsp_ready = 1'b1;
      tick();
      chk("release_ready", {cmd_ready, rsp_valid}, 2'b10);
      clear_mon();
      tick();
      cmd_valid = 1'b0;
      chk("s2_accept", {cmd_ready, vs_uir, vs_ir_in}, 4'b0111);

      // Scan 2: tdo tied high, strobe period counts
      wait_rsp(lat);
      chk("s2_latency", lat, 164);
      chk("s2_rsp_dr", rsp_dr, 38'h3F_FFFF_FFFF);
      chk("s2_n_uir", n_uir, 1);
      chk("s2_n_cdr", n_cdr, 1);
      chk("s2_n_sdr", n_sdr, 38);
      chk("s2_n_e1dr", n_e1dr, 1);
      chk("s2_tdi_seq", tdi_seq, 38'h15_5555_5555);
      tick();
      chk("b2b_ready", {cmd_ready, rsp_valid}, 2'b10);

      // Scan 3: reset during SDR bit 17
      tdo_tied = 1'b0; rsp_ready = 1'b0; clear_mon();
      cmd_ir = 2'b10; cmd_dr = 38'h0F_0F0F_0F0F; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      for (int k = 0; k < 400 && n_sdr < 18; k++) tick();
      chk("s3_reached_bit17", n_sdr, 18);
      reset = 1'b1;
      tick();
      chk("abort_strobes", {vs_uir, vs_cdr, vs_sdr, vs_e1dr, vs_rti}, 5'b00001);
      chk("abort_tck_tdi_ir", {vs_tck, vs_tdi, vs_ir_in}, 4'b0000);
      chk("abort_rsp", {rsp_valid, rsp_dr, rsp_ir}, 41'h0);
      reset = 1'b0;
      flag_ok = 1'b1;
      repeat (5) begin
         tick();
         if (rsp_valid !== 1'b0) flag_ok = 1'b0;
      end
      chk("abort_no_rsp", flag_ok, 1'b1);
      chk("abort_ready", cmd_ready, 1'b1);

      // Scan 4: fresh command after abort
      rsp_ready = 1'b1; clear_mon(); last_tdi = 1'b0; echo_tdo = 1'b0;
      cmd_ir = 2'b01; cmd_dr = 38'h3F_0000_0001; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      wait_rsp(lat);
      chk("s4_latency", lat, 164);
      chk("s4_rsp_dr", rsp_dr, 38'h3E_0000_0002);
      chk("s4_tdi_seq", tdi_seq, 38'h3F_0000_0001);
      chk("s4_n_sdr", n_sdr, 38);
      chk("s4_rsp_ir", rsp_ir, EXP_IR);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/niosinst_debug_scan_master.md
# niosinst_debug_scan_master

Host-side initiator for the 2-bit-IR / 38-bit-DR virtual-JTAG debug link. It sits on the system clock and drives the virtual-JTAG strobe bundle that the CPU debug slave consumes. It accepts one scan command (IR value plus 38-bit DR word), then sequences UIR → CDR → SDR×38 → E1DR on a divided TCK. It returns the 38 bits captured from TDO. It is used to exercise the debug slave in simulation and in FPGA self-test builds where no physical JTAG hub exists.

## Interface
Parameters:
- DR_WIDTH, 38, data-register scan length
- IR_WIDTH, 2, virtual IR width
- TCK_DIV, 2, clk cycles per TCK half-period (≥1)

Ports:
- clk  in  1  system clock; everything, including vs_tck generation, is synchronous to it
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  engine idle, command accepted when valid&&ready
- cmd_ir  in  IR_WIDTH  IR value presented during UIR
- cmd_dr  in  DR_WIDTH  word shifted out on vs_tdi, LSB first
- rsp_valid  out  1  capture complete, held until rsp_ready
- rsp_ready  in  1  response consumed
- rsp_dr  out  DR_WIDTH  captured TDO word; bit 0 = first bit sampled
- rsp_ir  out  IR_WIDTH  vs_ir_out captured during UIR (see Configuration)
- vs_tck  out  1  generated TCK
- vs_tdi  out  1  serial data to slave
- vs_tdo  in  1  serial data from slave
- vs_ir_in  out  IR_WIDTH  virtual IR
- vs_ir_out  in  IR_WIDTH  slave IR readback
- vs_uir, vs_cdr, vs_sdr, vs_e1dr, vs_rti  out  1 each  virtual TAP state strobes

## Operation
- States: IDLE, UIR, CDR, SDR, E1DR, RSP.
- In IDLE, vs_rti=1 and all other strobes are 0.
- cmd_ready = (state==IDLE).
- On accept, cmd_dr is latched into the shift register and cmd_ir into vs_ir_in. The engine goes to UIR.
- Each state boundary, tdi update and strobe update happens on a TCK falling event. TDO is sampled on the TCK rising event.
- UIR, CDR and E1DR each last exactly one TCK period. SDR lasts DR_WIDTH periods.
- Bit counter: counts 0..DR_WIDTH-1 in SDR. On the terminal count, the next falling event moves the engine to E1DR.
- SDR data path:
  - vs_tdi = shift register bit 0 throughout the period.
  - At the rising event, vs_tdo is shifted into the MSB of the capture register, which shifts right.
  - At the falling event, the tx register shifts right.
- After E1DR, the engine enters RSP with rsp_valid=1 and rsp_dr = the capture register.
- RSP → IDLE on rsp_valid&&rsp_ready.
- cmd_valid is ignored outside IDLE. cmd_* may change freely while busy.
- vs_ir_in holds the last accepted IR until the next accept.

## Timing
- Reset values (applied on the first clk edge with reset=1):
  - vs_tck=0, vs_tdi=0, vs_ir_in=0
  - vs_uir=vs_cdr=vs_sdr=vs_e1dr=0, vs_rti=1
  - rsp_valid=0, rsp_dr=0, rsp_ir=0
  - state=IDLE; cmd_ready=1 in the first cycle after reset deasserts.
- Reset mid-scan: the scan is aborted with no rsp_valid, and all outputs take their reset values on that edge.
- TCK period = 2·TCK_DIV clk cycles: low half first, then high half.
- TCK starts low on the accept edge and is free-running only outside IDLE/RSP. vs_tck is held 0 in IDLE and RSP.
- Latency: accept at edge N → rsp_valid rises at edge N + (DR_WIDTH+3)·2·TCK_DIV. Defaults give N+164.
- Strobes change only on falling events, so each strobe is stable for a full TCK period around its rising edge.
- Back-to-back: when rsp_ready=1 in the first RSP cycle, cmd_ready rises on the next cycle. The minimum command spacing is latency+2 cycles.

## Configuration
- NIOSINST_DEBUG_SCAN_IR_CAPTURE_EN:
  - Defined: vs_ir_out is sampled at the UIR rising event and presented on rsp_ir with rsp_dr.
  - Undefined: rsp_ir is tied 0 and no capture register is built.

## Structure
- Package niosinst_debug_scan_pkg holds the state enum and the DR_WIDTH_DEF/IR_WIDTH_DEF constants.
- Sub-module niosinst_debug_scan_tckgen is a divider counter producing vs_tck, a rise_en pulse and a fall_en pulse (one clk wide each), with an enable input.
- The top level holds the FSM, bit counter, and tx/capture shift registers.

## Test plan
- Reset, then idle for 10 cycles → vs_rti=1, vs_tck=0, cmd_ready=1, and all other outputs 0.
- cmd_ir=2'b01, cmd_dr=38'h2A_5A5A_5A5A, bench slave echoes tdi delayed one TCK:
  - vs_tdi bit sequence matches cmd_dr LSB first.
  - rsp_dr = (cmd_dr<<1) | previous-bit-0 model value.
  - rsp_valid rises at accept+164.
- vs_tdo tied 1, arbitrary cmd → rsp_dr=38'h3F_FFFF_FFFF. Strobe count: UIR 1, CDR 1, SDR 38, E1DR 1 TCK periods.
- rsp_ready held 0 for 20 cycles → rsp_valid and rsp_dr stable, cmd_ready=0, cmd_valid ignored. On release, the next command is accepted 1 cycle later.
- reset pulsed during SDR bit 17 → next cycle all outputs at reset values, no rsp_valid. A fresh command then completes normally.
- With NIOSINST_DEBUG_SCAN_IR_CAPTURE_EN and vs_ir_out=2'b10 → rsp_ir=2'b10. Without the macro → rsp_ir=0.
